// File: rtl/nukv_rotation_matrix_ctrl.sv
// Rotation-matrix configuration sequencer: loads a shadow matrix from a narrow config stream and
// commits it to the active matrix only between values, gating the value stream meanwhile.
module nukv_rotation_matrix_ctrl #(
    parameter int unsigned MEMORY_WIDTH = 512,
    parameter int unsigned COL_COUNT    = 3,
    parameter int unsigned COL_WIDTH    = 64,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [COL_WIDTH-1:0]                   cfg_data,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic                                   cfg_abort,
    input  logic [MEMORY_WIDTH-1:0]                in_data,
    input  logic                                   in_valid,
    input  logic                                   in_last,
    output logic                                   in_ready,
    output logic [MEMORY_WIDTH-1:0]                rot_data,
    output logic                                   rot_valid,
    output logic                                   rot_last,
    input  logic                                   rot_ready,
    output logic [COL_COUNT*COL_COUNT*COL_WIDTH-1:0] matrix_data,
    output logic                                   matrix_valid,
    output logic [CNT_WIDTH-1:0]                   value_count,
    output logic [CNT_WIDTH-1:0]                   commit_count
);

    localparam int unsigned N     = COL_COUNT * COL_COUNT;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StEmpty, StIdle, StBusy} state_e;

    state_e                 state_q;
    logic [IDX_W-1:0]       cfg_idx_q;
    logic                   shadow_full_q;
    logic [COL_WIDTH-1:0]   shadow_q [N];
    logic [COL_WIDTH-1:0]   active_q [N];
    logic [CNT_WIDTH-1:0]   value_count_q;
    logic [CNT_WIDTH-1:0]   commit_count_q;

    logic commit;
    logic gate;
    logic cfg_fire;
    logic val_fire;
    logic cfg_last_idx;

    // A pending shadow matrix takes over as soon as no value is in flight.
    assign commit       = shadow_full_q && (state_q != StBusy);
    assign gate         = rst && (state_q != StEmpty) && !commit;

    assign cfg_ready    = rst && !shadow_full_q;
    assign cfg_fire     = cfg_valid && cfg_ready && !cfg_abort;
    assign cfg_last_idx = (cfg_idx_q == IDX_W'(N - 1));

    assign rot_valid    = in_valid && gate;
    assign in_ready     = rot_ready && gate;
    assign rot_data     = in_data;
    assign rot_last     = in_last;
    assign val_fire     = in_valid && in_ready;

    assign matrix_valid = (state_q != StEmpty);
    assign value_count  = value_count_q;
    assign commit_count = commit_count_q;

    for (genvar k = 0; k < N; k++) begin : g_matrix
        assign matrix_data[k*COL_WIDTH +: COL_WIDTH] = active_q[k];
    end

    // Shadow loader
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_idx_q     <= '0;
            shadow_full_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            if (commit) begin
                shadow_full_q <= 1'b0;
            end
            if (!shadow_full_q && cfg_abort) begin
                cfg_idx_q <= '0;
            end else if (cfg_fire) begin
                shadow_q[cfg_idx_q] <= cfg_data;
                if (cfg_last_idx) begin
                    cfg_idx_q     <= '0;
                    shadow_full_q <= 1'b1;
                end else begin
                    cfg_idx_q <= cfg_idx_q + 1'b1;
                end
            end
        end
    end

    // Value-side FSM with active matrix and statistics
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StEmpty;
            value_count_q  <= '0;
            commit_count_q <= '0;
            for (int k = 0; k < N; k++) begin
                active_q[k] <= '0;
            end
        end else begin
            if (commit) begin
                commit_count_q <= commit_count_q + 1'b1;
                for (int k = 0; k < N; k++) begin
                    active_q[k] <= shadow_q[k];
                end
            end
            unique case (state_q)
                StEmpty: begin
                    if (shadow_full_q) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (val_fire) begin
                        if (in_last) begin
                            value_count_q <= value_count_q + 1'b1;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (val_fire && in_last) begin
                        value_count_q <= value_count_q + 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_nukv_rotation_matrix_ctrl.sv
// Self-checking bench: directed scenarios plus a random phase, compared every cycle against an
// abstract model of matrices, value boundaries and counters.
module tb_nukv_rotation_matrix_ctrl;

    localparam int MW = 512;
    localparam int CW = 64;
    localparam int N  = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic [CW-1:0]   cfg_data;
    logic            cfg_valid, cfg_ready, cfg_abort;
    logic [MW-1:0]   in_data;
    logic            in_valid, in_last, in_ready;
    logic [MW-1:0]   rot_data;
    logic            rot_valid, rot_last, rot_ready;
    logic [N*CW-1:0] matrix_data;
    logic            matrix_valid;
    logic [31:0]     value_count, commit_count;

    nukv_rotation_matrix_ctrl #(
        .MEMORY_WIDTH(MW), .COL_COUNT(3), .COL_WIDTH(CW), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_abort(cfg_abort),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .rot_data(rot_data), .rot_valid(rot_valid), .rot_last(rot_last), .rot_ready(rot_ready),
        .matrix_data(matrix_data), .matrix_valid(matrix_valid),
        .value_count(value_count), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Abstract model: a matrix is either absent or present, a value is either open or not.
    logic [CW-1:0] m_shadow [N];
    logic [CW-1:0] m_active [N];
    bit            m_has, m_mid, m_full;
    int            m_cnt;
    logic [31:0]   m_vc, m_cc;

    logic [CW-1:0] ld [N];
    logic [CW-1:0] mat_a [N];
    logic [CW-1:0] mat_b [N];
    logic [MW-1:0] beats [6];
    logic [MW-1:0] recv [$];
    bit            acc_v;

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*CW-1:0] pack(input logic [CW-1:0] m [N]);
        logic [N*CW-1:0] v;
        for (int k = 0; k < N; k++) v[k*CW +: CW] = m[k];
        return v;
    endfunction

    function automatic logic [MW-1:0] rand_wide();
        logic [MW-1:0] v;
        for (int i = 0; i < MW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_has = 0; m_mid = 0; m_full = 0; m_cnt = 0; m_vc = '0; m_cc = '0;
    endtask

    task automatic model_step();
        bit full_old, pass;
        if (!rst) begin
            model_reset();
            return;
        end
        full_old = m_full;
        pass     = m_has && !(m_full && !m_mid);
        if (m_full && !m_mid) begin
            m_active = m_shadow;
            m_full   = 0;
            m_has    = 1;
            m_cc++;
        end
        if (in_valid && rot_ready && pass) begin
            if (in_last) begin
                m_mid = 0;
                m_vc++;
            end else begin
                m_mid = 1;
            end
        end
        if (!full_old && cfg_abort) begin
            m_cnt = 0;
        end else if (cfg_valid && !full_old) begin
            m_shadow[m_cnt] = cfg_data;
            if (m_cnt == N - 1) begin
                m_cnt  = 0;
                m_full = 1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Checks outputs against the model, advances the model, then crosses one rising edge.
    task automatic cycle();
        bit pass;
        #1;
        pass = rst && m_has && !(m_full && !m_mid);
        check("cfg_ready", 640'(cfg_ready), 640'(rst && !m_full));
        check("in_ready", 640'(in_ready), 640'(pass && rot_ready));
        check("rot_valid", 640'(rot_valid), 640'(pass && in_valid));
        check("rot_data", 640'(rot_data), 640'(in_data));
        check("rot_last", 640'(rot_last), 640'(in_last));
        check("matrix_valid", 640'(matrix_valid), 640'(m_has));
        check("matrix_data", 640'(matrix_data), 640'(pack(m_active)));
        check("value_count", 640'(value_count), 640'(m_vc));
        check("commit_count", 640'(commit_count), 640'(m_cc));
        acc_v = in_valid && in_ready;
        if (rot_valid && rot_ready) recv.push_back(rot_data);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_ld();
        for (int k = 0; k < N; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = ld[k];
            cycle();
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] vc0, cc0;
        int idx;
        rst = 1'b0; cfg_data = '0; cfg_valid = 0; cfg_abort = 0;
        in_data = '0; in_valid = 0; in_last = 0; rot_ready = 1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        cycle();

        // 1: no matrix blocks the value stream; entries 1..9 commit one cycle after the last beat
        rst = 1'b1; in_valid = 1'b1; in_data = rand_wide();
        for (int i = 0; i < 3; i++) cycle();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) ld[k] = 64'(k + 1);
        load_ld();
        #1 check("t1_pre_commit_valid", 640'(matrix_valid), 640'(0));
        cycle();
        check("t1_valid", 640'(matrix_valid), 640'(1));
        check("t1_entry0", 640'(matrix_data[0 +: CW]), 640'(1));
        check("t1_entry8", 640'(matrix_data[8*CW +: CW]), 640'(9));
        check("t1_commits", 640'(commit_count), 640'(1));

        // 2: matrix B loaded mid-value only takes effect after the value ends
        for (int k = 0; k < N; k++) begin
            mat_a[k] = {$urandom, $urandom};
            mat_b[k] = {$urandom, $urandom};
            ld[k]    = mat_a[k];
        end
        load_ld();
        cycle();
        vc0 = m_vc; cc0 = m_cc;
        in_valid = 1'b1; in_last = 1'b0; in_data = rand_wide();
        cfg_valid = 1'b1; cfg_data = mat_b[0];
        cycle();
        for (int k = 1; k < N; k++) begin
            in_valid = (k == N - 1);
            in_data  = rand_wide();
            cfg_data = mat_b[k];
            cycle();
        end
        cfg_valid = 1'b0; in_valid = 1'b1; in_data = rand_wide();
        cycle();
        check("t2_matrix_a_b3", 640'(matrix_data), 640'(pack(mat_a)));
        in_last = 1'b1; in_data = rand_wide();
        cycle();
        check("t2_matrix_a_b4", 640'(matrix_data), 640'(pack(mat_a)));
        check("t2_value_count", 640'(value_count), 640'(vc0 + 1));
        in_last = 1'b0; in_data = rand_wide();
        #1 check("t2_gap_in_ready", 640'(in_ready), 640'(0));
        cycle();
        check("t2_matrix_b", 640'(matrix_data), 640'(pack(mat_b)));
        check("t2_commits", 640'(commit_count), 640'(cc0 + 1));
        #1 check("t2_next_in_ready", 640'(in_ready), 640'(1));
        cycle();
        in_last = 1'b1; in_data = rand_wide();
        cycle();

        // 3: back-to-back single-beat values
        vc0 = m_vc;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_last = 1'b1; in_data = rand_wide();
            #1 check("t3_accept", 640'(in_ready), 640'(1));
            cycle();
        end
        check("t3_value_count", 640'(value_count), 640'(vc0 + 3));

        // 4: throttled rotation side; the rot stream must equal the in stream
        recv.delete();
        for (int i = 0; i < 6; i++) beats[i] = rand_wide();
        idx = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            rot_ready = c[0];
            in_valid  = 1'b1;
            in_data   = beats[idx];
            in_last   = (idx == 5);
            cycle();
            if (acc_v) idx++;
        end
        in_valid = 1'b0; in_last = 1'b0; rot_ready = 1'b1;
        check("t4_beats_sent", 640'(idx), 640'(6));
        check("t4_beats_seen", 640'(recv.size()), 640'(6));
        for (int i = 0; i < 6 && i < recv.size(); i++) check("t4_beat", 640'(recv[i]), 640'(beats[i]));

        // 5: abort a partial load, then load C cleanly
        cc0 = m_cc;
        for (int k = 0; k < 5; k++) begin
            cfg_valid = 1'b1; cfg_data = {$urandom, $urandom};
            cycle();
        end
        cfg_abort = 1'b1; cfg_data = {$urandom, $urandom};
        cycle();
        cfg_abort = 1'b0;
        for (int k = 0; k < N; k++) ld[k] = {$urandom, $urandom};
        load_ld();
        cycle();
        check("t5_matrix_c", 640'(matrix_data), 640'(pack(ld)));
        check("t5_commits", 640'(commit_count), 640'(cc0 + 1));

        // 6: reset while busy with a commit pending
        in_valid = 1'b1; in_last = 1'b0; in_data = rand_wide();
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) ld[k] = {$urandom, $urandom};
        load_ld();
        #1 check("t6_cfg_stall", 640'(cfg_ready), 640'(0));
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1; in_valid = 1'b1; in_data = rand_wide();
        #1;
        check("t6_matrix_valid", 640'(matrix_valid), 640'(0));
        check("t6_cfg_ready", 640'(cfg_ready), 640'(1));
        check("t6_value_count", 640'(value_count), 640'(0));
        check("t6_commit_count", 640'(commit_count), 640'(0));
        check("t6_in_ready", 640'(in_ready), 640'(0));
        for (int i = 0; i < 3; i++) cycle();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) ld[k] = {$urandom, $urandom};
        load_ld();
        cycle();
        in_valid = 1'b1; in_last = 1'b1;
        #1 check("t6_resume", 640'(in_ready), 640'(1));
        cycle();

        // Random traffic on both streams
        for (int i = 0; i < 600; i++) begin
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_data  = {$urandom, $urandom};
            cfg_abort = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_last   = ($urandom_range(0, 3) == 0);
            in_data   = rand_wide();
            rot_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nukv_rotation_matrix_ctrl.md
# nukv_rotation_matrix_ctrl

Configuration sequencer in front of the privacy rotation datapath. Loads COL_COUNT×COL_COUNT rotation-matrix entries from a narrow config stream into a shadow register. Commits the shadow matrix to the active matrix only at value boundaries, so every value passing through the rotation module is rotated by exactly one matrix. Gates the value stream into the rotation module while no matrix is active or a commit is pending, and keeps value and commit counters.

## Interface

**Parameters**
- MEMORY_WIDTH, 512: value-stream beat width.
- COL_COUNT, 3: matrix dimension.
- COL_WIDTH, 64: matrix entry width; also the config word width.
- CNT_WIDTH, 32: width of the statistics counters.

**Ports**
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-low reset; rst=0 resets the block at the next edge.
- cfg_data, in, COL_WIDTH: one matrix entry per beat, row-major (entry k = row*COL_COUNT+col).
- cfg_valid, in, 1: config beat valid.
- cfg_ready, out, 1: config beat accepted when cfg_valid&&cfg_ready.
- cfg_abort, in, 1: discard a partially loaded shadow matrix.
- in_data, in, MEMORY_WIDTH: upstream value beat.
- in_valid, in, 1: upstream beat valid.
- in_last, in, 1: final beat of the value.
- in_ready, out, 1: upstream beat accepted.
- rot_data, out, MEMORY_WIDTH: beat to the rotation module.
- rot_valid, out, 1: beat to the rotation module is valid.
- rot_last, out, 1: final beat of the value, to the rotation module.
- rot_ready, in, 1: rotation module ready.
- matrix_data, out, COL_COUNT*COL_COUNT*COL_WIDTH: active matrix; entry k sits at [k*COL_WIDTH +: COL_WIDTH].
- matrix_valid, out, 1: an active matrix exists.
- value_count, out, CNT_WIDTH: number of values completed (accepted last beats).
- commit_count, out, CNT_WIDTH: number of matrix commits.

## Operation

**Shadow loader**
- N = COL_COUNT*COL_COUNT. Index cfg_idx runs 0..N-1.
- cfg_ready = !shadow_full; it is 0 while rst=0.
- Each accepted config beat writes shadow[cfg_idx] and increments cfg_idx.
- The beat accepted at cfg_idx=N-1 sets shadow_full=1 and returns cfg_idx to 0.
- cfg_abort=1 with shadow_full=0 clears cfg_idx to 0 and drops any beat offered in the same cycle.
- cfg_abort is ignored when shadow_full=1.

**Value-side FSM** (states EMPTY, IDLE, BUSY)
- gate = (state!=EMPTY) && !(shadow_full && state!=BUSY).
- Pass-through signals, combinational: rot_valid = in_valid&&gate; in_ready = rot_ready&&gate; rot_data = in_data; rot_last = in_last.
- A value beat counts as accepted when in_valid&&in_ready.
- EMPTY: on shadow_full, commit and go to IDLE.
- IDLE:
  - shadow_full: commit and stay in IDLE. No beat passes this cycle.
  - Otherwise, an accepted beat with in_last=0 moves to BUSY.
  - An accepted beat with in_last=1 (single-beat value) stays in IDLE and increments value_count.
- BUSY: an accepted beat with in_last=1 moves to IDLE and increments value_count. shadow_full never interrupts BUSY.
- Commit (one edge): active <= shadow; shadow_full <= 0; commit_count++.
- matrix_valid = (state!=EMPTY). matrix_data = active; it changes only on commit.
- Counters wrap modulo 2^CNT_WIDTH.

## Timing

**Reset** (rst=0 at an edge):
- state=EMPTY; shadow_full=0; cfg_idx=0; active=0.
- value_count=0; commit_count=0.
- Outputs: matrix_valid=0, in_ready=0, rot_valid=0, cfg_ready=0.
- Reset mid-value or mid-load discards everything. The upstream must restart at a value boundary.

**Latency**
- Data path has zero latency, with no registers between in_* and rot_*.
- Final config beat accepted at edge t gives shadow_full=1 after t. The commit edge is t+1 if state≠BUSY. The new matrix_data and matrix_valid are visible after t+1, and cfg_ready returns to 1 after t+1.
- Minimum spacing between commits is N+1 cycles.

**Simultaneous events**
- Last beat of a value accepted at edge t while shadow_full=1: state is IDLE after t, the commit happens at t+1, and the next value's first beat is accepted at t+2 at the earliest.
- A config beat and a value beat may be accepted in the same cycle; they are independent.
- The config stream stalls (cfg_ready=0) while shadow_full waits for a BUSY value to finish.

## Test plan

1. Reset, then in_valid=1 held with no config: in_ready and rot_valid stay 0 and matrix_valid stays 0. Load 9 entries 1..9: exactly 1 cycle after the 9th beat, matrix_valid=1, matrix_data entry 0 = 1 and entry 8 = 9, and commit_count=1.
2. Load matrix A, then send a 4-beat value. Start loading matrix B at beat 1 and complete it at beat 2. Required: matrix_data stays A through beat 4 (last); B commits the cycle after last; a queued next value starts 2 cycles after last; value_count=1.
3. Send three single-beat values (valid&last) back-to-back with rot_ready=1: three consecutive accepts, state stays IDLE, value_count=3.
4. With rot_ready toggling 1/0 each cycle mid-value: in_ready mirrors rot_ready, and no beat is duplicated or lost (compare rot stream with in stream).
5. Send 5 config beats, then cfg_abort=1, then 9 beats of C: the committed matrix equals C exactly, and commit_count increments once.
6. Drive rst=0 for one edge in BUSY with shadow_full=1: the next cycle shows matrix_valid=0, cfg_ready=1, counters 0, and in_ready=0 until a new full matrix commits.
